fetch_pc_gen: RTL and testbench

Fetch-stage PC generator sitting directly upstream of the tournament direction predictor. It holds the architectural fetch PC, drives it to the predictor and I-cache, and owns a direct-mapped branch target buffer (BTB). It combines the BTB hit and target with the predictor's taken bit to form the next fetch PC. Resolved branches from execute train the BTB, and mispredict redirects override everything.

---
 rtl/fetch_pc_gen_pkg.sv | 19 +
 rtl/btb_table.sv | 61 ++++++
 rtl/fetch_pc_gen.sv | 96 +++++++++
 tb/tb_fetch_pc_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared types and default sizes for the fetch PC generator and BTB
//
// Purpose: XLEN, default BTB geometry and the BTB entry layout, shared with the
//          execute stage so it can size its branch-resolution update fields.
// Ports:   none (package).
package fetch_pc_gen_pkg;

  localparam int XLEN              = 32;
  localparam int BTB_INDEX_LEN_DEF = 6;
  localparam int BTB_TAG_LEN_DEF   = 10;

  typedef struct packed {
    logic                       valid;
    logic [BTB_TAG_LEN_DEF-1:0] tag;
    logic [XLEN-1:0]            target;
    logic                       uncond;
  } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped BTB storage, one combinational read and one synchronous write port
//
// Purpose: holds 2^INDEX_LEN entries of {valid, tag, target, uncond}.
//          Only valid bits are reset; tag/target/uncond are don't-care until written.
// Ports:
//   clock, reset      : clock and synchronous active-high reset (clears all valid bits)
//   rd_index          : lookup index
//   rd_valid/rd_tag/rd_target/rd_uncond : combinational contents at rd_index (old data
//                       during a same-cycle write, no bypass)
//   wr_en, wr_index, wr_tag, wr_target, wr_uncond : write port, takes effect on the edge
module btb_table
  import fetch_pc_gen_pkg::*;
#(
  parameter int INDEX_LEN = BTB_INDEX_LEN_DEF,
  parameter int TAG_LEN   = BTB_TAG_LEN_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEX_LEN-1:0] rd_index,
  output logic                 rd_valid,
  output logic [TAG_LEN-1:0]   rd_tag,
  output logic [XLEN-1:0]      rd_target,
  output logic                 rd_uncond,
  input  logic                 wr_en,
  input  logic [INDEX_LEN-1:0] wr_index,
  input  logic [TAG_LEN-1:0]   wr_tag,
  input  logic [XLEN-1:0]      wr_target,
  input  logic                 wr_uncond
);

  localparam int DEPTH = 1 << INDEX_LEN;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_LEN-1:0] tag_mem    [DEPTH];
  logic [XLEN-1:0]    target_mem [DEPTH];
  logic               uncond_mem [DEPTH];

  // Reset wins over a write in the same cycle, so a write during reset is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Payload fields need no reset: an entry is only consulted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_index]    <= wr_tag;
      target_mem[wr_index] <= wr_target;
      uncond_mem[wr_index] <= wr_uncond;
    end
  end

  assign rd_valid  = valid_q[rd_index];
  assign rd_tag    = tag_mem[rd_index];
  assign rd_target = target_mem[rd_index];
  assign rd_uncond = uncond_mem[rd_index];

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC register, BTB lookup/training and next-PC selection
//
// Purpose: holds the fetch PC, looks it up in a direct-mapped BTB, combines the hit with
//          the direction predictor's taken bit to form next_PC, and applies redirects.
// Ports:
//   clock, reset    : clock and synchronous active-high reset
//   fetch_stall     : hold PC (a redirect still overrides)
//   predict_taken   : direction predictor taken bit for the current PC
//   redirect_valid, redirect_PC : execute-stage redirect, loaded on the next edge
//   result_valid, result_PC, result_target, result_taken, result_uncond : BTB training
//   PC              : current fetch PC
//   next_PC         : PC fetched next cycle absent stall/redirect
//   pred_taken      : fetch predicted to leave sequential flow
//   btb_hit         : valid BTB entry with matching tag for PC
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              BTB_INDEX_LEN = BTB_INDEX_LEN_DEF,
  parameter int              BTB_TAG_LEN   = BTB_TAG_LEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC      = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_stall,
  input  logic            predict_taken,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_PC,
  input  logic            result_valid,
  input  logic [XLEN-1:0] result_PC,
  input  logic [XLEN-1:0] result_target,
  input  logic            result_taken,
  input  logic            result_uncond,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] next_PC,
  output logic            pred_taken,
  output logic            btb_hit
);

  localparam int TAG_LO = BTB_INDEX_LEN + 2;
  localparam int TAG_HI = BTB_INDEX_LEN + BTB_TAG_LEN + 1;

  logic [XLEN-1:0]          pc_q;
  logic [BTB_INDEX_LEN-1:0] lookup_index;
  logic [BTB_TAG_LEN-1:0]   lookup_tag;
  logic                     entry_valid;
  logic [BTB_TAG_LEN-1:0]   entry_tag;
  logic [XLEN-1:0]          entry_target;
  logic                     entry_uncond;
  logic                     train_en;

  assign PC           = pc_q;
  assign lookup_index = pc_q[BTB_INDEX_LEN+1:2];
  assign lookup_tag   = pc_q[TAG_HI:TAG_LO];

  // Only taken or unconditional outcomes allocate; not-taken bias is the predictor's job.
  assign train_en = result_valid && (result_taken || result_uncond);

  btb_table #(
    .INDEX_LEN (BTB_INDEX_LEN),
    .TAG_LEN   (BTB_TAG_LEN)
  ) u_btb (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (lookup_index),
    .rd_valid  (entry_valid),
    .rd_tag    (entry_tag),
    .rd_target (entry_target),
    .rd_uncond (entry_uncond),
    .wr_en     (train_en),
    .wr_index  (result_PC[BTB_INDEX_LEN+1:2]),
    .wr_tag    (result_PC[TAG_HI:TAG_LO]),
    .wr_target (result_target),
    .wr_uncond (result_uncond)
  );

  assign btb_hit    = entry_valid && (entry_tag == lookup_tag);
  assign pred_taken = btb_hit && (entry_uncond || predict_taken);
  // Sequential add wraps modulo 2^XLEN.
  assign next_PC    = pred_taken ? entry_target : pc_q + XLEN'(4);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_PC;
    end else if (!fetch_stall) begin
      pc_q <= next_PC;
    end
  end

  // Word-offset and above-tag address bits do not participate in BTB lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_q[1:0], pc_q[XLEN-1:TAG_HI+1],
                            result_PC[1:0], result_PC[XLEN-1:TAG_HI+1]};

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen with directed vectors
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            fetch_stall;
  logic            predict_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_PC;
  logic            result_valid;
  logic [XLEN-1:0] result_PC;
  logic [XLEN-1:0] result_target;
  logic            result_taken;
  logic            result_uncond;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] next_PC;
  logic            pred_taken;
  logic            btb_hit;

  fetch_pc_gen #(
    .BTB_INDEX_LEN (6),
    .BTB_TAG_LEN   (10),
    .RESET_PC      (32'h0000_0100)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_stall    (fetch_stall),
    .predict_taken  (predict_taken),
    .redirect_valid (redirect_valid),
    .redirect_PC    (redirect_PC),
    .result_valid   (result_valid),
    .result_PC      (result_PC),
    .result_target  (result_target),
    .result_taken   (result_taken),
    .result_uncond  (result_uncond),
    .PC             (PC),
    .next_PC        (next_PC),
    .pred_taken     (pred_taken),
    .btb_hit        (btb_hit)
  );

  always #5 clock = ~clock;

  typedef struct {
    string           name;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            pred;
    logic            hit;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Monitor: outputs are combinational, so they are settled at the falling edge.
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_compared++;
      if ({PC, next_PC, pred_taken, btb_hit} !== {e.pc, e.npc, e.pred, e.hit}) begin
        n_mismatched++;
        $display("FAIL %s: got PC=%h next_PC=%h pred=%b hit=%b, want PC=%h next_PC=%h pred=%b hit=%b",
                 e.name, PC, next_PC, pred_taken, btb_hit, e.pc, e.npc, e.pred, e.hit);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    result_valid   = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] npc, input logic pred, input logic hit);
    exp_t e;
    e.name = name; e.pc = pc; e.npc = npc; e.pred = pred; e.hit = hit;
    sb.push_back(e);
  endtask

  task automatic train(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                       input logic taken, input logic uncond);
    result_valid  = 1'b1;
    result_PC     = pc;
    result_target = tgt;
    result_taken  = taken;
    result_uncond = uncond;
  endtask

  task automatic redirect(input logic [XLEN-1:0] pc);
    redirect_valid = 1'b1;
    redirect_PC    = pc;
  endtask

  initial begin
    reset = 1'b1; fetch_stall = 1'b0; predict_taken = 1'b0;
    redirect_valid = 1'b0; redirect_PC = '0;
    result_valid = 1'b0; result_PC = '0; result_target = '0;
    result_taken = 1'b0; result_uncond = 1'b0;
    step();
    step();
    reset = 1'b0;
    expect_out("reset_state", 32'h100, 32'h104, 1'b0, 1'b0);
    step();
    expect_out("seq_104", 32'h104, 32'h108, 1'b0, 1'b0);
    step();
    expect_out("seq_108", 32'h108, 32'h10C, 1'b0, 1'b0);
    train(32'h120, 32'h200, 1'b1, 1'b0);
    redirect(32'h120);

    step();
    fetch_stall = 1'b1; predict_taken = 1'b1;
    expect_out("cond_taken", 32'h120, 32'h200, 1'b1, 1'b1);
    step();
    predict_taken = 1'b0;
    expect_out("cond_not_taken", 32'h120, 32'h124, 1'b0, 1'b1);
    train(32'h140, 32'h300, 1'b1, 1'b1);
    redirect(32'h140);

    step();
    expect_out("jal_pt0", 32'h140, 32'h300, 1'b1, 1'b1);
    step();
    predict_taken = 1'b1;
    expect_out("jal_pt1", 32'h140, 32'h300, 1'b1, 1'b1);
    fetch_stall = 1'b0;
    step();
    predict_taken = 1'b0;
    expect_out("jal_followed", 32'h300, 32'h304, 1'b0, 1'b0);
    train(32'h10120, 32'h400, 1'b1, 1'b0);
    redirect(32'h120);

    step();
    fetch_stall = 1'b1; predict_taken = 1'b1;
    expect_out("alias_miss", 32'h120, 32'h124, 1'b0, 1'b0);
    step();
    expect_out("stall_1", 32'h120, 32'h124, 1'b0, 1'b0);
    step();
    expect_out("stall_2", 32'h120, 32'h124, 1'b0, 1'b0);
    step();
    expect_out("stall_3", 32'h120, 32'h124, 1'b0, 1'b0);
    redirect(32'h500);

    step();
    train(32'h500, 32'h600, 1'b1, 1'b0);
    expect_out("redirect_stalled_no_bypass", 32'h500, 32'h504, 1'b0, 1'b0);
    step();
    expect_out("write_visible_next", 32'h500, 32'h600, 1'b1, 1'b1);
    redirect(32'hFFFF_FFFC);

    step();
    expect_out("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    fetch_stall = 1'b0;
    step();
    fetch_stall = 1'b1;
    train(32'h0, 32'h700, 1'b0, 1'b0);
    expect_out("wrapped_to_zero", 32'h0, 32'h4, 1'b0, 1'b0);
    step();
    expect_out("not_taken_no_alloc", 32'h0, 32'h4, 1'b0, 1'b0);
    reset = 1'b1;
    train(32'h0, 32'h800, 1'b1, 1'b0);

    step();
    reset = 1'b0;
    expect_out("mid_reset", 32'h100, 32'h104, 1'b0, 1'b0);
    redirect(32'h10120);
    step();
    expect_out("reset_cleared_alias", 32'h10120, 32'h10124, 1'b0, 1'b0);
    redirect(32'h0);
    step();
    expect_out("reset_write_dropped", 32'h0, 32'h4, 1'b0, 1'b0);
    redirect(32'h500);
    step();
    expect_out("reset_cleared_500", 32'h500, 32'h504, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
